// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: branch mode encodings,
// 2-bit predictor counter states, the result payload and counter helpers.
package branch_resolve_unit_pkg;

  // Branch mode encodings carried on i_branch
  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLEZ = 3'b011,
    BR_BGTZ = 3'b100,
    BR_BLTZ = 3'b101,
    BR_BGEZ = 3'b110,
    BR_RSVD = 3'b111
  } br_mode_e;

  // 2-bit saturating predictor states; bit 1 is the prediction
  localparam logic [1:0] CTR_SNT   = 2'b00;
  localparam logic [1:0] CTR_WNT   = 2'b01;
  localparam logic [1:0] CTR_WT    = 2'b10;
  localparam logic [1:0] CTR_ST    = 2'b11;
  localparam logic [1:0] CTR_RESET = CTR_WNT;

  // Registered resolve result
  typedef struct packed {
    logic valid;
    logic taken;
    logic mispredict;
  } resolve_res_t;

  // True for the six real branch modes (excludes none and reserved)
  function automatic logic is_branch_mode(input logic [2:0] mode);
    return (mode != BR_NONE) && (mode != BR_RSVD);
  endfunction

  // One saturating step of a predictor counter toward the actual outcome
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator.
// Ports: data1, data2 - signed comparands; mode - branch mode; taken - outcome.
// Modes none and reserved evaluate to not-taken.
module branch_cond_eval
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [2:0]        mode,
  output logic              taken
);

  localparam logic signed [DATA_W-1:0] ZERO = '0;

  logic signed [DATA_W-1:0] s1;
  logic signed [DATA_W-1:0] s2;

  assign s1 = $signed(data1);
  assign s2 = $signed(data2);

  // Signed compare selected by mode
  always_comb begin
    taken = 1'b0;
    case (br_mode_e'(mode))
      BR_BEQ:  taken = (s1 == s2);
      BR_BNE:  taken = (s1 != s2);
      BR_BLEZ: taken = (s1 <= ZERO);
      BR_BGTZ: taken = (s1 >  ZERO);
      BR_BLTZ: taken = (s1 <  ZERO);
      BR_BGEZ: taken = (s1 >= ZERO);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit with a 2-bit bimodal predictor table.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_lookup_pc / o_pred_taken     fetch-side prediction (combinational read)
//   i_valid, i_pc, i_data1/2,      resolve request; outcome and mispredict
//   i_branch, i_pred_taken,        are registered one cycle later on
//   i_flush                        o_valid / o_taken / o_mispredict
//   o_branch_cnt, o_mispred_cnt    saturating statistics counters
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [PC_W-1:0]   i_lookup_pc,
  output logic              o_pred_taken,
  input  logic              i_valid,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [DATA_W-1:0] i_data1,
  input  logic [DATA_W-1:0] i_data2,
  input  logic [2:0]        i_branch,
  input  logic              i_pred_taken,
  input  logic              i_flush,
  output logic              o_valid,
  output logic              o_taken,
  output logic              o_mispredict,
  output logic [CNT_W-1:0]  o_branch_cnt,
  output logic [CNT_W-1:0]  o_mispred_cnt
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] update_idx;
  logic             outcome_c;
  logic             accept_c;
  resolve_res_t     res_d;
  resolve_res_t     res_q;
  logic [CNT_W-1:0] branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_d;
  logic             unused_pc_bits;

  // Word-aligned PCs: drop the byte offset before indexing
  assign lookup_idx = i_lookup_pc[IDX_W+1:2];
  assign update_idx = i_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{i_lookup_pc[PC_W-1:IDX_W+2], i_lookup_pc[1:0],
                            i_pc[PC_W-1:IDX_W+2], i_pc[1:0]};

  // Read port sees the stored value only, so a same-cycle update is not bypassed
  assign o_pred_taken = bht[lookup_idx][1];

  branch_cond_eval #(
    .DATA_W (DATA_W)
  ) u_cond (
    .data1 (i_data1),
    .data2 (i_data2),
    .mode  (i_branch),
    .taken (outcome_c)
  );

  assign accept_c = i_valid && !i_flush && is_branch_mode(i_branch);

  // Next result and saturating statistics
  always_comb begin
    res_d         = '0;
    branch_cnt_d  = o_branch_cnt;
    mispred_cnt_d = o_mispred_cnt;
    if (accept_c) begin
      res_d.valid      = 1'b1;
      res_d.taken      = outcome_c;
      res_d.mispredict = outcome_c ^ i_pred_taken;
      if (o_branch_cnt != '1) branch_cnt_d = o_branch_cnt + CNT_W'(1);
      if (res_d.mispredict && (o_mispred_cnt != '1)) begin
        mispred_cnt_d = o_mispred_cnt + CNT_W'(1);
      end
    end
  end

  // Result and counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res_q         <= '0;
      o_branch_cnt  <= '0;
      o_mispred_cnt <= '0;
    end else begin
      res_q         <= res_d;
      o_branch_cnt  <= branch_cnt_d;
      o_mispred_cnt <= mispred_cnt_d;
    end
  end

  assign o_valid      = res_q.valid;
  assign o_taken      = res_q.taken;
  assign o_mispredict = res_q.mispredict;

  // Predictor table: flop array, single write port
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[IDX_W'(i)] <= CTR_RESET;
      end
    end else if (accept_c) begin
      bht[update_idx] <= ctr_step(bht[update_idx], outcome_c);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus
// random traffic against an arithmetic reference model.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] lookup_pc;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [2:0]  branch;
  logic        pred_in;
  logic        flush;

  logic        pred_out, o_valid, o_taken, o_mispredict;
  logic [31:0] bcnt, mcnt;
  logic        pred_out4, o_valid4, o_taken4, o_mispredict4;
  logic [3:0]  bcnt4, mcnt4;

  int     n_checks;
  int     n_fail;
  int     model_bht [64];
  longint exp_bc, exp_mc, exp_bc4, exp_mc4;

  branch_resolve_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_lookup_pc(lookup_pc), .o_pred_taken(pred_out),
    .i_valid(valid), .i_pc(pc), .i_data1(data1), .i_data2(data2), .i_branch(branch),
    .i_pred_taken(pred_in), .i_flush(flush), .o_valid(o_valid), .o_taken(o_taken),
    .o_mispredict(o_mispredict), .o_branch_cnt(bcnt), .o_mispred_cnt(mcnt)
  );

  branch_resolve_unit #(.CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_lookup_pc(lookup_pc), .o_pred_taken(pred_out4),
    .i_valid(valid), .i_pc(pc), .i_data1(data1), .i_data2(data2), .i_branch(branch),
    .i_pred_taken(pred_in), .i_flush(flush), .o_valid(o_valid4), .o_taken(o_taken4),
    .o_mispredict(o_mispredict4), .o_branch_cnt(bcnt4), .o_mispred_cnt(mcnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] br, input int d1, input int d2);
    case (br)
      3'd1: return d1 == d2;
      3'd2: return d1 != d2;
      3'd3: return d1 <= 0;
      3'd4: return d1 > 0;
      3'd5: return d1 < 0;
      3'd6: return d1 >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic longint sat_inc(input longint v, input longint lim);
    return (v >= lim) ? lim : v + 1;
  endfunction

  // One resolve cycle: drive, check prediction, clock, check results
  task automatic step(input bit v, input logic [2:0] br, input int d1, input int d2,
                      input logic [31:0] rpc, input logic [31:0] lpc, input bit pt,
                      input bit fl);
    bit tk, acc, mp;
    int uidx;
    valid = v; branch = br; data1 = d1; data2 = d2; pc = rpc; lookup_pc = lpc;
    pred_in = pt; flush = fl;
    #1;
    chk("pred", pred_out, model_bht[(lpc >> 2) % 64] >= 2);
    chk("pred4", pred_out4, model_bht[(lpc >> 2) % 64] >= 2);
    tk  = ref_taken(br, d1, d2);
    acc = v && !fl && br >= 1 && br <= 6;
    mp  = acc && (tk != pt);
    uidx = (rpc >> 2) % 64;
    @(posedge clk);
    #1;
    if (acc) begin
      model_bht[uidx] = tk ? ((model_bht[uidx] == 3) ? 3 : model_bht[uidx] + 1)
                           : ((model_bht[uidx] == 0) ? 0 : model_bht[uidx] - 1);
      exp_bc  = sat_inc(exp_bc, 64'hFFFF_FFFF);
      exp_bc4 = sat_inc(exp_bc4, 15);
      if (mp) begin
        exp_mc  = sat_inc(exp_mc, 64'hFFFF_FFFF);
        exp_mc4 = sat_inc(exp_mc4, 15);
      end
    end
    chk("valid", o_valid, acc);
    chk("taken", o_taken, acc && tk);
    chk("mispredict", o_mispredict, mp);
    chk("valid4", o_valid4, acc);
    chk("branch_cnt", bcnt, exp_bc);
    chk("mispred_cnt", mcnt, exp_mc);
    chk("branch_cnt4", bcnt4, exp_bc4);
    chk("mispred_cnt4", mcnt4, exp_mc4);
  endtask

  task automatic idle(input logic [31:0] lpc);
    step(1'b0, 3'd0, 0, 0, 32'h0, lpc, 1'b0, 1'b0);
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge
  task automatic do_reset();
    valid = 1'b0; flush = 1'b0; branch = 3'd0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_taken", o_taken, 1'b0);
    chk("rst_mispredict", o_mispredict, 1'b0);
    chk("rst_branch_cnt", bcnt, 0);
    chk("rst_mispred_cnt", mcnt, 0);
    chk("rst_branch_cnt4", bcnt4, 0);
    foreach (model_bht[i]) model_bht[i] = 1;
    exp_bc = 0; exp_mc = 0; exp_bc4 = 0; exp_mc4 = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int rand_data();
    if ($urandom_range(0, 3) == 0) return int'($urandom);
    return int'($urandom_range(0, 4)) - 2;
  endfunction

  initial begin
    n_checks = 0; n_fail = 0;
    lookup_pc = '0; pc = '0; data1 = '0; data2 = '0; pred_in = 1'b0;
    valid = 1'b0; flush = 1'b0; branch = 3'd0; rst_n = 1'b0;
    #1;
    do_reset();

    // Every entry starts weakly not-taken
    for (int i = 0; i < 64; i++) begin
      lookup_pc = 32'(i << 2);
      #1;
      chk("init_pred", pred_out, 1'b0);
    end

    // beq 5,5 predicted not-taken at 0x40: taken, mispredict, entry -> 10
    step(1'b1, 3'd1, 5, 5, 32'h40, 32'h40, 1'b0, 1'b0);
    idle(32'h40);
    chk("entry16_pred", pred_out, 1'b1);

    // bgtz walk at 0x80, then saturate at strong-taken and step back
    step(1'b1, 3'd4, -1, 0, 32'h80, 32'h80, 1'b1, 1'b0);
    step(1'b1, 3'd4, 0, 0, 32'h80, 32'h80, 1'b1, 1'b0);
    step(1'b1, 3'd4, 1, 0, 32'h80, 32'h80, 1'b1, 1'b0);
    step(1'b1, 3'd4, 32'h7FFF_FFFF, 0, 32'h80, 32'h80, 1'b1, 1'b0);
    repeat (3) step(1'b1, 3'd4, 7, 0, 32'h80, 32'h80, 1'b1, 1'b0);
    step(1'b1, 3'd4, -7, 0, 32'h80, 32'h80, 1'b1, 1'b0);
    idle(32'h80);
    chk("sat_no_wrap_pred", pred_out, 1'b1);

    // Flushed bltz: discarded
    step(1'b1, 3'd5, -5, 0, 32'h40, 32'h40, 1'b0, 1'b1);
    // Reserved and none modes are never accepted
    step(1'b1, 3'd7, 1, 1, 32'h40, 32'h40, 1'b1, 1'b0);
    step(1'b1, 3'd0, 1, 1, 32'h40, 32'h40, 1'b1, 1'b0);

    // Same-index lookup and update: old value now, new value next cycle
    step(1'b1, 3'd1, 3, 3, 32'hC0, 32'hC0, 1'b0, 1'b0);
    idle(32'hC0);

    // Random traffic over a small index range to force collisions
    for (int n = 0; n < 400; n++) begin
      logic [31:0] rpc, lpc;
      rpc = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 7) << 2);
      lpc = ($urandom_range(0, 1) == 0) ? rpc
          : (($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 7) << 2));
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rand_data(), rand_data(),
           rpc, lpc, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
    end

    // Reset with a result pending, then behave as from power-up
    step(1'b1, 3'd1, 9, 9, 32'h40, 32'h40, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 3'd1, 5, 5, 32'h40, 32'h40, 1'b0, 1'b0);
    idle(32'h40);

    // Narrow counters saturate at 15
    do_reset();
    repeat (17) step(1'b1, 3'd1, 1, 1, 32'h100, 32'h100, 1'b0, 1'b0);
    chk("cnt4_branch_sat", bcnt4, 4'd15);
    chk("cnt4_mispred_sat", mcnt4, 4'd15);
    chk("cnt32_branch", bcnt, 17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, comparand width.
REQ-002 SHALL have parameter PC_W, default 32, PC width.
REQ-003 SHALL have parameter BHT_DEPTH, default 64, number of 2-bit predictor entries; power of two, at least 4; IDX_W = log2(BHT_DEPTH).
REQ-004 SHALL have parameter CNT_W, default 32, statistics counter width.
REQ-005 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 i_rst_n  input  1  reset; asynchronous, active-low.
REQ-007 i_lookup_pc  input  PC_W  fetch-stage PC for prediction.
REQ-008 o_pred_taken  output  1  combinational prediction: MSB of entry at i_lookup_pc[IDX_W+1:2].
REQ-009 i_valid  input  1  resolve request present this cycle.
REQ-010 i_pc  input  PC_W  PC of the resolving branch.
REQ-011 i_data1, i_data2  input  DATA_W  signed comparands.
REQ-012 i_branch  input  3  mode: 000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 bgez, 111 reserved.
REQ-013 i_pred_taken  input  1  prediction used when the branch was fetched.
REQ-014 i_flush  input  1  kill in-flight and incoming resolve.
REQ-015 o_valid  output  1  registered resolve result valid.
REQ-016 o_taken  output  1  registered actual outcome.
REQ-017 o_mispredict  output  1  registered; o_taken differs from i_pred_taken.
REQ-018 o_branch_cnt, o_mispred_cnt  output  CNT_W  resolved-branch and mispredict counts.

Function
REQ-019 Outcome SHALL be combinational on signed compare: beq eq; bne ne; blez data1<=0; bgtz data1>0; bltz data1<0; bgez data1>=0; modes 000/111 give not-taken.
REQ-020 An accepted resolve SHALL require i_valid=1, i_flush=0 and i_branch in 001..110.
REQ-021 An accepted resolve SHALL set o_valid=1, o_taken and o_mispredict on the next edge; otherwise the next edge SHALL set all three to 0. Latency is exactly 1 cycle, with no stall.
REQ-022 An accepted resolve SHALL update the entry at i_pc[IDX_W+1:2] on the same edge: taken increments, not-taken decrements, saturating at 00 and 11.
REQ-023 Entry states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; prediction = bit 1.
REQ-024 When a lookup and an update hit the same index in one cycle, o_pred_taken SHALL return the pre-update value (no bypass).
REQ-025 Each accepted resolve SHALL add 1 to o_branch_cnt; each accepted mispredict SHALL add 1 to o_mispred_cnt; both saturate at all-ones and never wrap.
REQ-026 i_flush=1 SHALL discard the same-cycle request: no table update, no count, o_valid=0 next cycle.
REQ-027 Back-to-back accepted resolves to the same index SHALL each apply their step sequentially, with no lost update.

Reset
REQ-028 Asserting i_rst_n low SHALL immediately clear o_valid, o_taken, o_mispredict and both counters, and set every entry to 01.
REQ-029 Reset asserted mid-operation SHALL drop any pending result; the first accepted resolve after deassertion SHALL behave as from power-up.

Structure
REQ-030 A shared package SHALL hold branch mode encodings, the 2-bit counter state constants, and reset value 01.
REQ-031 Compare/mode decode SHALL be one combinational sub-module, branch_cond_eval (data1, data2, mode -> taken).
REQ-032 The table SHALL be flop-based with 1 combinational read and 1 write port; no memory macro.

Verification
REQ-033 Reset, then lookup pc=0x40 -> o_pred_taken=0; every entry reads 01.
REQ-034 beq 5,5 with pred=0 at pc=0x40 -> next cycle o_valid=1, o_taken=1, o_mispredict=1; entry 16 = 10; lookup 0x40 -> 1; counts 1/1.
REQ-035 Four taken bgtz data1=-1,0,1,0x7FFFFFFF at pc=0x80 -> outcomes 0,0,1,1; entry saturates and does not wrap.
REQ-036 Valid bltz with i_flush=1 -> o_valid=0 next cycle, table and counts unchanged.
REQ-037 Update and lookup at same index in one cycle -> old prediction returned; new value visible the following cycle.
REQ-038 CNT_W=4, drive 17 mispredicts -> both counters hold 15.
